// File: rtl/jit_template_sequencer_pkg.sv
// Shared types and constants for the JIT template sequencer: FSM states, trap codes,
// special instruction-address ROM values and template word field positions.
package jit_template_sequencer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOOKUP = 3'd1,
    FETCH  = 3'd2,
    EMIT   = 3'd3,
    TRAP   = 3'd4
  } state_t;

  localparam logic [1:0] TRAP_NONE        = 2'd0;
  localparam logic [1:0] TRAP_UNSUPPORTED = 2'd1;
  localparam logic [1:0] TRAP_ILLEGAL     = 2'd2;
  localparam logic [1:0] TRAP_OVERRUN     = 2'd3;

  localparam logic [6:0] ADR_NONE     = 7'd0;
  localparam logic [6:0] ADR_ILLEGAL  = 7'd127;
  localparam logic [6:0] ADR_LAST_PC  = 7'd126;

  // Template ROM word layout: {patch, last, word[31:0]}
  localparam int TW_PATCH    = 33;
  localparam int TW_LAST     = 32;
  localparam int TW_WORD_MSB = 31;

endpackage

// File: rtl/jit_template_sequencer_if.sv
// Bytecode, ROM and ARM-word handshake bundle around the template sequencer.
// master = sequencer side, slave = surrounding front end / ROMs.
interface jit_template_sequencer_if;
  logic        bc_valid;
  logic        bc_ready;
  logic [7:0]  bc_opcode;
  logic [15:0] bc_operand;
  logic [8:0]  adr_rom_in;
  logic [6:0]  adr_rom_out;
  logic        tmpl_en;
  logic [6:0]  tmpl_addr;
  logic [33:0] tmpl_data;
  logic        arm_valid;
  logic        arm_ready;
  logic [31:0] arm_word;
  logic        arm_last;
  logic        trap_valid;
  logic [1:0]  trap_code;
  logic [7:0]  trap_opcode;
  logic        busy;

  modport master (
    input  bc_valid, bc_opcode, bc_operand, adr_rom_out, tmpl_data, arm_ready,
    output bc_ready, adr_rom_in, tmpl_en, tmpl_addr, arm_valid, arm_word, arm_last,
           trap_valid, trap_code, trap_opcode, busy
  );

  modport slave (
    output bc_valid, bc_opcode, bc_operand, adr_rom_out, tmpl_data, arm_ready,
    input  bc_ready, adr_rom_in, tmpl_en, tmpl_addr, arm_valid, arm_word, arm_last,
           trap_valid, trap_code, trap_opcode, busy
  );
endinterface

// File: rtl/jit_template_sequencer.sv
// Per-bytecode control: looks up the template start for {wide, opcode}, then walks the
// template ROM emitting one (optionally operand-patched) ARM word per handshake.
module jit_template_sequencer
  import jit_template_sequencer_pkg::*;
#(
  parameter int         MAX_TMPL_LEN = 16,
  parameter logic [7:0] WIDE_OPCODE  = 8'hC4,
  parameter int         PATCH_BITS   = 12
) (
  input logic                      clk,
  input logic                      rst_n,
  jit_template_sequencer_if.master bus
);

  localparam int CNT_W = (MAX_TMPL_LEN > 1) ? $clog2(MAX_TMPL_LEN) : 1;

  state_t             state, state_nxt;
  logic               wide_q;
  logic               wide_lat_q;
  logic [7:0]         opcode_q;
  logic [15:0]        operand_q;
  logic [6:0]         pc_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [1:0]         trap_q;
  logic               emit_first_q;
  logic [33:0]        hold_q;
  logic [33:0]        tmpl_cur;
  logic [31:0]        word_out;
  logic               overrun;

  // The ROM word is only on tmpl_data in the first EMIT cycle; afterwards the held copy is used
  assign tmpl_cur = emit_first_q ? bus.tmpl_data : hold_q;
  assign overrun  = (int'(cnt_q) == MAX_TMPL_LEN - 1) || (pc_q == ADR_LAST_PC);

  always_comb begin
    word_out = tmpl_cur[TW_WORD_MSB:0];
    if (tmpl_cur[TW_PATCH])
      word_out[PATCH_BITS-1:0] = operand_q[PATCH_BITS-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wide_q       <= 1'b0;
      pc_q         <= '0;
      cnt_q        <= '0;
      trap_q       <= TRAP_NONE;
      emit_first_q <= 1'b0;
    end else begin
      state        <= state_nxt;
      emit_first_q <= (state == FETCH);
      if (state == IDLE && bus.bc_valid)
        wide_q <= (bus.bc_opcode == WIDE_OPCODE);
      if (state == LOOKUP) begin
        pc_q  <= bus.adr_rom_out;
        cnt_q <= '0;
        if (bus.adr_rom_out == ADR_NONE)
          trap_q <= TRAP_UNSUPPORTED;
        else if (bus.adr_rom_out == ADR_ILLEGAL)
          trap_q <= TRAP_ILLEGAL;
      end
      if (state == EMIT && bus.arm_ready && !tmpl_cur[TW_LAST]) begin
        if (overrun)
          trap_q <= TRAP_OVERRUN;
        else begin
          pc_q  <= pc_q + 7'd1;
          cnt_q <= cnt_q + 1'b1;
        end
      end
    end
  end

  // Operand/opcode and the held template word are pure data: no reset needed
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.bc_valid && bus.bc_opcode != WIDE_OPCODE) begin
      opcode_q   <= bus.bc_opcode;
      operand_q  <= bus.bc_operand;
      wide_lat_q <= wide_q;
    end
    if (state == EMIT)
      hold_q <= tmpl_cur;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:
        if (bus.bc_valid && bus.bc_opcode != WIDE_OPCODE)
          state_nxt = LOOKUP;
      LOOKUP:
        if (bus.adr_rom_out == ADR_NONE || bus.adr_rom_out == ADR_ILLEGAL)
          state_nxt = TRAP;
        else
          state_nxt = FETCH;
      FETCH:
        state_nxt = EMIT;
      EMIT:
        if (bus.arm_ready) begin
          if (tmpl_cur[TW_LAST])
            state_nxt = IDLE;
          else if (overrun)
            state_nxt = TRAP;
          else
            state_nxt = FETCH;
        end
      TRAP:
        state_nxt = IDLE;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_comb begin
    bus.bc_ready    = (state == IDLE);
    bus.busy        = (state != IDLE);
    bus.adr_rom_in  = '0;
    bus.tmpl_en     = 1'b0;
    bus.tmpl_addr   = '0;
    bus.arm_valid   = 1'b0;
    bus.arm_word    = '0;
    bus.arm_last    = 1'b0;
    bus.trap_valid  = 1'b0;
    bus.trap_code   = '0;
    bus.trap_opcode = '0;
    case (state)
      LOOKUP: bus.adr_rom_in = {wide_lat_q, opcode_q};
      FETCH: begin
        bus.tmpl_en   = 1'b1;
        bus.tmpl_addr = pc_q;
      end
      EMIT: begin
        bus.arm_valid = 1'b1;
        bus.arm_word  = word_out;
        bus.arm_last  = tmpl_cur[TW_LAST];
      end
      TRAP: begin
        bus.trap_valid  = 1'b1;
        bus.trap_code   = trap_q;
        bus.trap_opcode = opcode_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_jit_template_sequencer.sv
// Bench for jit_template_sequencer: behavioural ROMs plus a template-walk reference model.
module tb_jit_template_sequencer;
  import jit_template_sequencer_pkg::*;

  localparam logic [7:0] WIDE = 8'hC4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  jit_template_sequencer_if bus();

  jit_template_sequencer #(
    .MAX_TMPL_LEN(16),
    .WIDE_OPCODE (8'hC4),
    .PATCH_BITS  (12)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  logic [6:0]  adr_rom [0:511];
  logic [33:0] tmpl    [0:127];

  assign bus.adr_rom_out = adr_rom[bus.adr_rom_in];
  always @(posedge clk) if (bus.tmpl_en) bus.tmpl_data <= tmpl[bus.tmpl_addr];

  logic [31:0] obs_words[$], exp_words[$];
  bit          obs_last[$],  exp_last[$];
  logic [6:0]  obs_addr[$],  exp_addr[$];
  logic [8:0]  obs_index, exp_index;
  logic [1:0]  obs_trap_code, exp_trap;
  logic [7:0]  obs_trap_op;
  int          first_valid_cyc, valid_cycles, trap_cnt, ready_busy, stable_err;
  bit          timeout, model_wide;
  int          total = 0;
  int          bad = 0;

  // Reference: walk the template from its start address following the documented rules
  task automatic model(input logic [8:0] idx, input logic [15:0] opnd);
    logic [6:0]  start, pc;
    logic [33:0] e;
    logic [31:0] w;
    exp_words.delete(); exp_last.delete(); exp_addr.delete();
    exp_trap  = 2'd0;
    exp_index = idx;
    start = adr_rom[idx];
    if (start == 7'd0) exp_trap = 2'd1;
    else if (start == 7'd127) exp_trap = 2'd2;
    else begin
      for (int n = 0; n < 16; n++) begin
        pc = start + 7'(n);
        e  = tmpl[pc];
        w  = e[31:0];
        if (e[33]) w[11:0] = opnd[11:0];
        exp_addr.push_back(pc);
        exp_words.push_back(w);
        exp_last.push_back(e[32]);
        if (e[32]) break;
        if (n == 15 || pc == 7'd126) begin
          exp_trap = 2'd3;
          break;
        end
      end
    end
  endtask

  task automatic run_bc(input logic [7:0] op, input logic [15:0] opnd,
                        input int stall_pct, input int hold);
    int w, cyc, held;
    logic [31:0] prev;
    bit pend;
    obs_words.delete(); obs_last.delete(); obs_addr.delete();
    obs_index = 'x; obs_trap_code = 0; obs_trap_op = 0;
    first_valid_cyc = 0; valid_cycles = 0; trap_cnt = 0; ready_busy = 0; stable_err = 0;
    timeout = 0;
    if (op != WIDE) model({model_wide, op}, opnd);
    w = 0;
    while (!bus.bc_ready && w < 50) begin @(posedge clk); #1; w++; end
    if (!bus.bc_ready) begin timeout = 1; return; end
    bus.bc_valid = 1'b1; bus.bc_opcode = op; bus.bc_operand = opnd;
    @(posedge clk); #1;
    bus.bc_valid = 1'b0;
    model_wide = (op == WIDE);
    if (op == WIDE) return;
    cyc = 1; held = 0; pend = 0; prev = '0;
    while (bus.busy && cyc < 200) begin
      if (cyc == 1) obs_index = bus.adr_rom_in;
      if (bus.tmpl_en) obs_addr.push_back(bus.tmpl_addr);
      if (bus.bc_ready) ready_busy++;
      if (bus.trap_valid) begin
        trap_cnt++; obs_trap_code = bus.trap_code; obs_trap_op = bus.trap_opcode;
      end
      if (bus.arm_valid) begin
        valid_cycles++;
        if (first_valid_cyc == 0) first_valid_cyc = cyc;
        if (pend && bus.arm_word !== prev) stable_err++;
      end
      if (bus.arm_valid && held < hold) begin bus.arm_ready = 1'b0; held++; end
      else bus.arm_ready = ($urandom_range(0, 99) >= stall_pct);
      if (bus.arm_valid && bus.arm_ready) begin
        obs_words.push_back(bus.arm_word); obs_last.push_back(bus.arm_last); pend = 0;
      end else if (bus.arm_valid) begin
        pend = 1; prev = bus.arm_word;
      end
      @(posedge clk); #1; cyc++;
    end
    if (bus.busy) timeout = 1;
    bus.arm_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (bus.bc_ready !== 1'b1) begin bad++; $display("FAIL reset_bc_ready got %b want 1", bus.bc_ready); end
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got %b want 0", bus.busy); end
    total++; if ({bus.arm_valid, bus.trap_valid, bus.tmpl_en} !== 3'b000) begin bad++;
      $display("FAIL reset_outputs got %b want 000", {bus.arm_valid, bus.trap_valid, bus.tmpl_en}); end
    total++; if (bus.adr_rom_in !== 9'h000) begin bad++; $display("FAIL reset_adr got %h want 000", bus.adr_rom_in); end
  endtask

  task automatic test_basic();
    run_bc(8'h0B, 16'($urandom), 0, 0);
    total++; if (timeout) begin bad++; $display("FAIL basic_timeout got 1 want 0"); end
    total++; if (obs_index !== 9'h00B) begin bad++; $display("FAIL basic_index got %h want 00b", obs_index); end
    total++; if (obs_addr.size() != 3 || obs_addr[0] !== 7'd11 || obs_addr[1] !== 7'd12 || obs_addr[2] !== 7'd13) begin
      bad++; $display("FAIL basic_addr got n=%0d first=%0d want 11,12,13", obs_addr.size(), obs_addr[0]); end
    total++; if (first_valid_cyc != 3) begin bad++; $display("FAIL basic_latency got %0d want 3", first_valid_cyc); end
    total++; if (obs_words.size() != exp_words.size()) begin bad++;
      $display("FAIL basic_count got %0d want %0d", obs_words.size(), exp_words.size()); end
    for (int i = 0; i < exp_words.size() && i < obs_words.size(); i++) begin
      total++; if (obs_words[i] !== exp_words[i] || obs_last[i] !== exp_last[i]) begin bad++;
        $display("FAIL basic_word%0d got %h/%b want %h/%b", i, obs_words[i], obs_last[i], exp_words[i], exp_last[i]); end
    end
    total++; if (trap_cnt != 0) begin bad++; $display("FAIL basic_trap got %0d want 0", trap_cnt); end
  endtask

  task automatic test_wide();
    run_bc(WIDE, 16'h0, 0, 0);
    total++; if (bus.busy !== 1'b0 || bus.bc_ready !== 1'b1) begin bad++;
      $display("FAIL wide_idle got busy=%b ready=%b want 0/1", bus.busy, bus.bc_ready); end
    run_bc(8'h00, 16'h1234, 0, 0);
    total++; if (obs_index !== 9'h100) begin bad++; $display("FAIL wide_index got %h want 100", obs_index); end
    total++; if (obs_addr.size() == 0 || obs_addr[0] !== 7'd2) begin bad++; $display("FAIL wide_start got %0d want 2", obs_addr[0]); end
    total++; if (obs_words != exp_words || trap_cnt != 0) begin bad++;
      $display("FAIL wide_words got n=%0d trap=%0d want n=%0d trap=0", obs_words.size(), trap_cnt, exp_words.size()); end
    run_bc(8'h00, 16'h0, 0, 0);
    total++; if (obs_index !== 9'h000) begin bad++; $display("FAIL wide_cleared got %h want 000", obs_index); end
  endtask

  task automatic test_trap_unsupported();
    run_bc(8'h00, 16'h0, 0, 0);
    total++; if (trap_cnt != 1 || obs_trap_code !== 2'd1) begin bad++;
      $display("FAIL trap1_code got n=%0d code=%0d want 1/1", trap_cnt, obs_trap_code); end
    total++; if (obs_trap_op !== 8'h00) begin bad++; $display("FAIL trap1_op got %h want 00", obs_trap_op); end
    total++; if (valid_cycles != 0) begin bad++; $display("FAIL trap1_novalid got %0d want 0", valid_cycles); end
  endtask

  task automatic test_trap_illegal();
    run_bc(WIDE, 16'h0, 0, 0);
    run_bc(8'h41, 16'h0, 0, 0);
    total++; if (obs_index !== 9'h141) begin bad++; $display("FAIL trap2_index got %h want 141", obs_index); end
    total++; if (trap_cnt != 1 || obs_trap_code !== 2'd2 || obs_trap_op !== 8'h41) begin bad++;
      $display("FAIL trap2_code got n=%0d code=%0d op=%h want 1/2/41", trap_cnt, obs_trap_code, obs_trap_op); end
    total++; if (valid_cycles != 0) begin bad++; $display("FAIL trap2_novalid got %0d want 0", valid_cycles); end
  endtask

  task automatic test_patch_stall();
    logic [33:0] e;
    e = tmpl[20];
    run_bc(8'h10, 16'h0ABC, 0, 5);
    total++; if (obs_words.size() == 0 || obs_words[0] !== {e[31:12], 12'hABC}) begin bad++;
      $display("FAIL patch_word got %h want %h", obs_words[0], {e[31:12], 12'hABC}); end
    total++; if (stable_err != 0) begin bad++; $display("FAIL patch_stable got %0d changes want 0", stable_err); end
    total++; if (ready_busy != 0) begin bad++; $display("FAIL patch_bc_ready got %0d want 0", ready_busy); end
    total++; if (obs_words != exp_words || obs_last != exp_last) begin bad++;
      $display("FAIL patch_words got n=%0d want n=%0d", obs_words.size(), exp_words.size()); end
  endtask

  task automatic test_overrun();
    run_bc(8'h11, 16'($urandom), 30, 0);
    total++; if (obs_words.size() != 16 || obs_words != exp_words) begin bad++;
      $display("FAIL overrun16_words got n=%0d want 16", obs_words.size()); end
    total++; if (trap_cnt != 1 || obs_trap_code !== 2'd3 || obs_trap_op !== 8'h11) begin bad++;
      $display("FAIL overrun16_trap got n=%0d code=%0d op=%h want 1/3/11", trap_cnt, obs_trap_code, obs_trap_op); end
    run_bc(8'h12, 16'($urandom), 0, 0);
    total++; if (obs_words.size() != 7 || obs_words != exp_words || obs_trap_code !== 2'd3) begin bad++;
      $display("FAIL overrun126 got n=%0d code=%0d want 7/3", obs_words.size(), obs_trap_code); end
  endtask

  task automatic test_reset_mid_emit();
    int w;
    bus.arm_ready = 1'b0;
    bus.bc_valid = 1'b1; bus.bc_opcode = 8'h0B; bus.bc_operand = 16'h0;
    @(posedge clk); #1;
    bus.bc_valid = 1'b0;
    model_wide = 0;
    w = 0;
    while (!bus.arm_valid && w < 20) begin @(posedge clk); #1; w++; end
    total++; if (bus.arm_valid !== 1'b1) begin bad++; $display("FAIL rstmid_reach got %b want 1", bus.arm_valid); end
    #2 rst_n = 1'b0;
    #1;
    total++; if (bus.arm_valid !== 1'b0 || bus.busy !== 1'b0 || bus.bc_ready !== 1'b1) begin bad++;
      $display("FAIL rstmid_idle got valid=%b busy=%b ready=%b want 0/0/1", bus.arm_valid, bus.busy, bus.bc_ready); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    run_bc(8'h0B, 16'h0, 0, 0);
    total++; if (obs_words != exp_words || first_valid_cyc != 3) begin bad++;
      $display("FAIL rstmid_restart got n=%0d lat=%0d want n=%0d lat=3", obs_words.size(), first_valid_cyc, exp_words.size()); end
  endtask

  task automatic test_random();
    logic [7:0] ops [10];
    logic [7:0] op;
    ops = '{8'h0B, 8'h00, 8'h10, 8'h11, 8'h12, 8'h2A, 8'h3B, WIDE, 8'h41, 8'hFE};
    for (int it = 0; it < 40; it++) begin
      op = ops[$urandom_range(0, 9)];
      run_bc(op, 16'($urandom), $urandom_range(0, 60), 0);
      if (op == WIDE) begin
        total++; if (bus.busy !== 1'b0 || timeout) begin bad++; $display("FAIL rand%0d_wide got busy=%b want 0", it, bus.busy); end
      end else begin
        total++; if (timeout || obs_index !== exp_index) begin bad++;
          $display("FAIL rand%0d_index got %h to=%b want %h", it, obs_index, timeout, exp_index); end
        total++; if (obs_words != exp_words || obs_last != exp_last || obs_addr != exp_addr) begin bad++;
          $display("FAIL rand%0d_words op=%h got n=%0d want n=%0d", it, op, obs_words.size(), exp_words.size()); end
        total++; if (trap_cnt != (exp_trap != 0 ? 1 : 0) || obs_trap_code !== exp_trap) begin bad++;
          $display("FAIL rand%0d_trap got n=%0d code=%0d want code=%0d", it, trap_cnt, obs_trap_code, exp_trap); end
      end
    end
  endtask

  initial begin
    bus.bc_valid = 1'b0; bus.bc_opcode = '0; bus.bc_operand = '0; bus.arm_ready = 1'b0;
    model_wide = 0;
    for (int i = 0; i < 512; i++) adr_rom[i] = 7'd0;
    for (int i = 0; i < 128; i++) tmpl[i] = {2'b00, 32'($urandom)};
    adr_rom[9'h00B] = 7'd11;  tmpl[13][32] = 1'b1;
    adr_rom[9'h100] = 7'd2;   tmpl[3][32]  = 1'b1;
    adr_rom[9'h141] = 7'd127;
    adr_rom[9'h0FE] = 7'd127;
    adr_rom[9'h010] = 7'd20;  tmpl[20][33] = 1'b1; tmpl[21][33] = 1'b1; tmpl[21][32] = 1'b1;
    adr_rom[9'h011] = 7'd40;  tmpl[45][33] = 1'b1;
    adr_rom[9'h012] = 7'd120; tmpl[122][33] = 1'b1;
    adr_rom[9'h02A] = 7'd60;  tmpl[62][33] = 1'b1; tmpl[64][32] = 1'b1;
    adr_rom[9'h03B] = 7'd70;  tmpl[71][33] = 1'b1; tmpl[73][32] = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    test_basic();
    test_wide();
    test_trap_unsupported();
    test_trap_illegal();
    test_patch_stall();
    test_overrun();
    test_reset_mid_emit();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
